// File: rtl/vga_fb_arbiter_if.sv
// Writer handshake and framebuffer RAM bus shared by the arbiter and its environment.
// The slave side is the arbiter; the master side is the writer plus the RAM.
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output wr_valid, wr_addr, wr_data, mem_rdata,
        input  wr_ready, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, mem_rdata,
        output wr_ready, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scan-out reads own the RAM during active display,
// queued writer traffic is drained through a small FIFO during blanking.
module vga_fb_arbiter #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [9:0]                  posx,
    input  logic [9:0]                  posy,
    input  logic                        blank_n,
    vga_fb_arbiter_if.slave             bus,
    output logic [DATA_W-1:0]           pix_data,
    output logic                        pix_valid,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] q_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level;
    logic              full, empty, push, pop;

    logic              rd_ok;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              vld_p0, vld_p1, zero_p0, zero_p1;

    // Modulo-2^ADDR_W arithmetic gives the same result as a full-width product truncated.
    function automatic logic [ADDR_W-1:0] scan_addr(input logic [9:0] x, input logic [9:0] y);
        return ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
    endfunction

    function automatic logic in_active(input logic [9:0] x, input logic [9:0] y);
        return (int'(x) < WIDTH) && (int'(y) < HEIGHT);
    endfunction

    assign full          = (level == LVL_W'(FIFO_DEPTH));
    assign empty         = (level == '0);
    assign push          = bus.wr_valid && !full;
    assign bus.wr_ready  = !full;
    assign fifo_level    = level;
    assign rd_ok         = in_active(posx, posy);
    // The registered state doubles as the write strobe: DRAIN in cycle t is a write at t+1.
    assign bus.mem_we    = (state == DRAIN);

    always_comb begin
        state_nxt = IDLE;
        pop       = 1'b0;
        addr_nxt  = bus.mem_addr;
        wdata_nxt = bus.mem_wdata;
        if (blank_n) begin
            state_nxt = SCAN;
            if (rd_ok) begin
                addr_nxt = scan_addr(posx, posy);
            end
        end else if (!empty) begin
            state_nxt = DRAIN;
            pop       = 1'b1;
            addr_nxt  = q_addr[rd_ptr];
            wdata_nxt = q_data[rd_ptr];
        end
    end

    // Stage p0: RAM command register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            state         <= state_nxt;
            bus.mem_addr  <= addr_nxt;
            bus.mem_wdata <= wdata_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= bus.wr_addr;
            q_data[wr_ptr] <= bus.wr_data;
        end
    end

    // Stage p1: RAM returns data; stage p2: pixel output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0    <= 1'b0;
            zero_p0   <= 1'b0;
            vld_p1    <= 1'b0;
            zero_p1   <= 1'b0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
        end else begin
            vld_p0    <= blank_n;
            zero_p0   <= !rd_ok;
            vld_p1    <= vld_p0;
            zero_p1   <= zero_p0;
            pix_valid <= vld_p1;
            pix_data  <= (vld_p1 && !zero_p1) ? bus.mem_rdata : '0;
        end
    end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a queue-based scoreboard for RAM writes and pixels.
// The RAM model returns address[7:0] ^ 8'hA0 one cycle after the address.
module tb_vga_fb_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] posx = '0;
    logic [9:0] posy = '0;
    logic       blank_n = 1'b0;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic [2:0] fifo_level;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct { int due; logic [7:0] data; } pix_t;
    typedef struct { logic [18:0] addr; logic [7:0] data; } wr_t;
    pix_t exp_pix[$];
    wr_t  exp_wr[$];

    vga_fb_arbiter_if #(.ADDR_W(19), .DATA_W(8)) bus ();

    vga_fb_arbiter #(
        .WIDTH(640), .HEIGHT(480), .ADDR_W(19), .DATA_W(8), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .posx(posx), .posy(posy), .blank_n(blank_n),
        .bus(bus), .pix_data(pix_data), .pix_valid(pix_valid), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.mem_rdata <= bus.mem_addr[7:0] ^ 8'hA0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT presents a write or a pixel.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (bus.mem_we) begin
                if (exp_wr.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected", bus.mem_addr, bus.mem_wdata);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk("wr_addr", 32'(bus.mem_addr), 32'(w.addr));
                    chk("wr_data", 32'(bus.mem_wdata), 32'(w.data));
                end
            end
            if (pix_valid) begin
                if (exp_pix.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pixel: data %0h, none expected", pix_data);
                end else begin
                    pix_t p;
                    p = exp_pix.pop_front();
                    chk("pix_cycle", 32'(cyc), 32'(p.due));
                    chk("pix_data", 32'(pix_data), 32'(p.data));
                end
            end else begin
                chk("blank_pix_zero", 32'(pix_data), 32'h0);
                if (exp_pix.size() > 0 && exp_pix[0].due <= cyc) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL missing_pixel: pix_valid 0, expected data %0h at cycle %0d", exp_pix[0].data, exp_pix[0].due);
                    void'(exp_pix.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scan_cycle(input logic [9:0] x, input logic [9:0] y, input logic [7:0] px);
        pix_t p;
        posx = x;
        posy = y;
        blank_n = 1'b1;
        p.due = cyc + 3;
        p.data = px;
        exp_pix.push_back(p);
        step();
    endtask

    task automatic blank_cycle();
        blank_n = 1'b0;
        step();
    endtask

    task automatic queue_write(input logic [18:0] a, input logic [7:0] d);
        wr_t w;
        bus.wr_valid = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        w.addr = a;
        w.data = d;
        exp_wr.push_back(w);
    endtask

    logic [18:0] fa [5] = '{19'd100, 19'd200, 19'd300, 19'd307300, 19'd999};
    logic [7:0]  fd [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;

        // Reset state
        #13;
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'h1);
        chk("rst_fifo_level", 32'(fifo_level), 32'h0);
        chk("rst_pix_valid", 32'(pix_valid), 32'h0);
        chk("rst_pix_data", 32'(pix_data), 32'h0);
        #10 rst = 1'b1;
        step();

        // Scan address and latency
        scan_cycle(10'd5, 10'd2, 8'hA5);
        chk("scan_addr_5_2", 32'(bus.mem_addr), 32'd1285);
        chk("scan_mem_we", 32'(bus.mem_we), 32'h0);
        repeat (4) blank_cycle();

        // Corner pixel and out-of-range pixels
        scan_cycle(10'd0, 10'd0, 8'hA0);
        chk("scan_addr_0_0", 32'(bus.mem_addr), 32'd0);
        scan_cycle(10'd639, 10'd479, 8'h5F);
        chk("scan_addr_last", 32'(bus.mem_addr), 32'd307199);
        scan_cycle(10'd700, 10'd3, 8'h00);
        chk("oor_x_no_read", 32'(bus.mem_addr), 32'd307199);
        scan_cycle(10'd5, 10'd480, 8'h00);
        chk("oor_y_no_read", 32'(bus.mem_addr), 32'd307199);
        repeat (4) blank_cycle();

        // Fill during active display: 5th write refused
        for (int i = 0; i < 5; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr = fa[i];
            bus.wr_data = fd[i];
            chk("fill_wr_ready", 32'(bus.wr_ready), (i < 4) ? 32'h1 : 32'h0);
            if (i < 4) begin
                wr_t w;
                w.addr = fa[i];
                w.data = fd[i];
                exp_wr.push_back(w);
            end
            scan_cycle(10'd10, 10'd0, 8'hAA);
            chk("fill_mem_we", 32'(bus.mem_we), 32'h0);
        end
        bus.wr_valid = 1'b0;
        chk("fill_level", 32'(fifo_level), 32'd4);

        // Drain in blanking
        for (int i = 0; i < 4; i++) begin
            blank_cycle();
            chk("drain_mem_we", 32'(bus.mem_we), 32'h1);
            chk("drain_level", 32'(fifo_level), 32'(3 - i));
        end
        blank_cycle();
        chk("drain_idle_we", 32'(bus.mem_we), 32'h0);
        chk("drain_idle_level", 32'(fifo_level), 32'd0);
        chk("drain_idle_hold_addr", 32'(bus.mem_addr), 32'd307300);
        repeat (3) blank_cycle();

        // blank_n rising mid-drain
        for (int i = 0; i < 4; i++) begin
            queue_write(19'(1000 + i), 8'(8'h61 + i));
            scan_cycle(10'd10, 10'd0, 8'hAA);
        end
        bus.wr_valid = 1'b0;
        blank_cycle();
        chk("rise_w1_we", 32'(bus.mem_we), 32'h1);
        blank_cycle();
        chk("rise_w2_addr", 32'(bus.mem_addr), 32'd1001);
        chk("rise_level_2", 32'(fifo_level), 32'd2);
        scan_cycle(10'd1, 10'd0, 8'hA1);
        chk("rise_read_we", 32'(bus.mem_we), 32'h0);
        chk("rise_read_addr", 32'(bus.mem_addr), 32'd1);
        scan_cycle(10'd2, 10'd0, 8'hA2);
        chk("rise_level_held", 32'(fifo_level), 32'd2);

        // Full-boundary push while popping
        queue_write(19'd3000, 8'h81);
        scan_cycle(10'd10, 10'd0, 8'hAA);
        queue_write(19'd3001, 8'h82);
        scan_cycle(10'd10, 10'd0, 8'hAA);
        bus.wr_valid = 1'b1;
        bus.wr_addr = 19'd2000;
        bus.wr_data = 8'h77;
        chk("full_wr_ready", 32'(bus.wr_ready), 32'h0);
        blank_cycle();
        bus.wr_valid = 1'b0;
        chk("full_pop_level", 32'(fifo_level), 32'd3);
        chk("full_pop_addr", 32'(bus.mem_addr), 32'd1002);
        repeat (3) blank_cycle();
        blank_cycle();
        chk("full_drained_level", 32'(fifo_level), 32'd0);
        repeat (3) blank_cycle();

        // Reset mid-drain
        for (int i = 0; i < 4; i++) begin
            queue_write(19'(4000 + i), 8'(8'h90 + i));
            scan_cycle(10'd10, 10'd0, 8'hAA);
        end
        bus.wr_valid = 1'b0;
        blank_cycle();
        chk("pre_rst_level", 32'(fifo_level), 32'd3);
        #2 rst = 1'b0;
        exp_wr.delete();
        exp_pix.delete();
        #1;
        chk("async_rst_we", 32'(bus.mem_we), 32'h0);
        chk("async_rst_level", 32'(fifo_level), 32'd0);
        chk("async_rst_pix_valid", 32'(pix_valid), 32'h0);
        chk("async_rst_wr_ready", 32'(bus.wr_ready), 32'h1);
        @(negedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            blank_cycle();
            chk("post_rst_no_write", 32'(bus.mem_we), 32'h0);
        end
        chk("post_rst_level", 32'(fifo_level), 32'd0);

        repeat (4) blank_cycle();
        chk("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
        chk("pix_queue_drained", 32'(exp_pix.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
